// File: rtl/miscv_pipe_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
package miscv_pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } pipe_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam int          DEF_REG_W = 4;

  // Per-cycle pipeline register control bundle
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_bubble;
    logic mul_busy;
  } pipe_ctrl_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX feeding a source of the ID instruction.
module hazard_detect
  import miscv_pipe_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic             MemRead,
  input  logic [REG_W-1:0] Rd,
  input  logic [REG_W-1:0] Rs,
  input  logic [REG_W-1:0] Rt,
  input  logic             UsesRt,
  output logic             LoadUse
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign LoadUse = MemRead && (Rd != '0) && ((Rd == Rs) || (UsesRt && (Rd == Rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: PC/IF/ID/EX/MEM enables, flushes and bubbles.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import miscv_pipe_pkg::*;
#(
  parameter int REG_W      = DEF_REG_W,
  parameter int MUL_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             ResetN,
  input  logic             IMemReady,
  input  logic             DMemReady,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic             EX_BranchTaken,
  input  logic             EX_MulStart,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             EXMEMBubble,
  output logic             MulBusy,
  output logic [15:0]      StallCnt,
  output logic [15:0]      FlushCnt
);

  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_LOAD  = MUL_MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;

  pipe_state_e state, state_nxt;
  logic [3:0]  mul_cnt, mul_cnt_nxt;
  logic        load_use;
  logic        mul_stall;
  logic        flush_evt;
  pipe_ctrl_t  ctrl;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .MemRead (IDEX_MemRead),
    .Rd      (IDEX_Rd),
    .Rs      (IFID_Rs),
    .Rt      (IFID_Rt),
    .UsesRt  (IFID_UsesRt),
    .LoadUse (load_use)
  );

  assign mul_stall = (state == MUL_WAIT) || (EX_MulStart && MUL_MULTI);

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state   <= RUN;
      mul_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  // Frozen cycles (DMemReady=0) neither advance nor start the multiply sequence.
  // The wait ends as the count drains through 1, so the front end sees exactly
  // MUL_CYCLES-1 unfrozen stall cycles including the start cycle.
  always_comb begin
    state_nxt   = state;
    mul_cnt_nxt = mul_cnt;
    if (DMemReady) begin
      case (state)
        RUN: begin
          if (EX_MulStart && MUL_MULTI) begin
            state_nxt   = MUL_WAIT;
            mul_cnt_nxt = MUL_LOAD;
          end
        end
        MUL_WAIT: begin
          if (mul_cnt <= 4'd1) begin
            state_nxt   = RUN;
            mul_cnt_nxt = 4'd0;
          end else begin
            mul_cnt_nxt = mul_cnt - 4'd1;
          end
        end
        default: begin
          state_nxt   = RUN;
          mul_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl      = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1, default: 1'b0};
    flush_evt = 1'b0;
    if (!ResetN) begin
      ctrl = '{ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b1, default: 1'b0};
    end else if (!DMemReady) begin
      ctrl          = '0;
      ctrl.mul_busy = (state == MUL_WAIT);
    end else if (mul_stall) begin
      ctrl.pc_write     = 1'b0;
      ctrl.ifid_write   = 1'b0;
      ctrl.idex_write   = 1'b0;
      ctrl.exmem_bubble = 1'b1;
      ctrl.mul_busy     = 1'b1;
    end else if (EX_BranchTaken) begin
      // Branch wins over a coincident load-use: the dependent instruction is squashed anyway
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_bubble = 1'b1;
      flush_evt        = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_write  = 1'b0;
      ctrl.idex_bubble = 1'b1;
    end else if (!IMemReady) begin
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_flush = 1'b1;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign IFIDWrite   = ctrl.ifid_write;
  assign IDEXWrite   = ctrl.idex_write;
  assign IFIDFlush   = ctrl.ifid_flush;
  assign IDEXBubble  = ctrl.idex_bubble;
  assign EXMEMBubble = ctrl.exmem_bubble;
  assign MulBusy     = ctrl.mul_busy;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      if (!ctrl.pc_write) stall_q <= sat_inc16(stall_q);
      if (flush_evt)      flush_q <= sat_inc16(flush_q);
    end
  end

  assign StallCnt = stall_q;
  assign FlushCnt = flush_q;
`else
  logic unused_perf;
  assign unused_perf = flush_evt;
  assign StallCnt    = 16'h0000;
  assign FlushCnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MUL_CYCLES=4); counter checks follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  logic        CLK = 1'b0;
  logic        ResetN;
  logic        IMemReady, DMemReady;
  logic [3:0]  IFID_Rs, IFID_Rt, IDEX_Rd;
  logic        IFID_UsesRt, IDEX_MemRead, EX_BranchTaken, EX_MulStart;
  logic        PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXBubble, EXMEMBubble, MulBusy;
  logic [15:0] StallCnt, FlushCnt;

  int checks = 0;
  int errors = 0;

  // {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXBubble, EXMEMBubble, MulBusy}
  localparam logic [6:0] C_RUN   = 7'b1110000;
  localparam logic [6:0] C_RST   = 7'b0001110;
  localparam logic [6:0] C_LU    = 7'b0010100;
  localparam logic [6:0] C_BR    = 7'b1111100;
  localparam logic [6:0] C_MUL   = 7'b0000011;
  localparam logic [6:0] C_IMISS = 7'b0111000;
  localparam logic [6:0] C_FRZ   = 7'b0000000;
  localparam logic [6:0] C_FRZM  = 7'b0000001;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipe_ctrl #(.REG_W(4), .MUL_CYCLES(4)) dut (
    .CLK(CLK), .ResetN(ResetN), .IMemReady(IMemReady), .DMemReady(DMemReady),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rd(IDEX_Rd), .EX_BranchTaken(EX_BranchTaken),
    .EX_MulStart(EX_MulStart), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble), .EXMEMBubble(EXMEMBubble), .MulBusy(MulBusy),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] ctl();
    return {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXBubble, EXMEMBubble, MulBusy};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    IMemReady = 1'b1; DMemReady = 1'b1;
    IFID_Rs = 4'd0; IFID_Rt = 4'd0; IFID_UsesRt = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_Rd = 4'd0;
    EX_BranchTaken = 1'b0; EX_MulStart = 1'b0;
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    set_idle();
    tick();
    tick();
    ResetN = 1'b1;
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    IMemReady = 1'b1; DMemReady = 1'b1;
    IFID_Rs = 4'hF; IFID_Rt = 4'hF; IFID_UsesRt = 1'b1;
    IDEX_MemRead = 1'b1; IDEX_Rd = 4'hF;
    EX_BranchTaken = 1'b1; EX_MulStart = 1'b1;
    tick();
    @(negedge CLK);
    checks++;
    if (ctl() !== C_RST) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl(), C_RST);
    end
    checks++;
    if (StallCnt !== 16'h0 || FlushCnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %h/%h expected 0000/0000", StallCnt, FlushCnt);
    end
    tick();
    set_idle();
    ResetN = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_RUN) begin
      errors++; $display("FAIL post_reset_run: got %b expected %b", ctl(), C_RUN);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_Rd = 4'd3; IFID_Rs = 4'd3;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_LU) begin
      errors++; $display("FAIL load_use_rs: got %b expected %b", ctl(), C_LU);
    end
    tick();
    IDEX_MemRead = 1'b0;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_RUN) begin
      errors++; $display("FAIL load_use_one_cycle: got %b expected %b", ctl(), C_RUN);
    end
    tick();
    IDEX_MemRead = 1'b1; IDEX_Rd = 4'd0; IFID_Rs = 4'd0;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_RUN) begin
      errors++; $display("FAIL load_use_r0: got %b expected %b", ctl(), C_RUN);
    end
    tick();
    IDEX_Rd = 4'd3; IFID_Rs = 4'd5; IFID_Rt = 4'd3; IFID_UsesRt = 1'b0;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_RUN) begin
      errors++; $display("FAIL load_use_rt_unused: got %b expected %b", ctl(), C_RUN);
    end
    tick();
    IFID_UsesRt = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_LU) begin
      errors++; $display("FAIL load_use_rt: got %b expected %b", ctl(), C_LU);
    end
    tick();
    set_idle();
  endtask

  task automatic test_branch();
    do_reset();
    EX_BranchTaken = 1'b1;
    IDEX_MemRead = 1'b1; IDEX_Rd = 4'd3; IFID_Rs = 4'd3;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_BR) begin
      errors++; $display("FAIL branch_over_load_use: got %b expected %b", ctl(), C_BR);
    end
    tick();
    set_idle();
    @(negedge CLK);
    checks++;
    if (FlushCnt !== (PERF ? 16'd1 : 16'd0) || StallCnt !== 16'd0) begin
      errors++;
      $display("FAIL branch_counters: got flush=%0d stall=%0d expected flush=%0d stall=0",
               FlushCnt, StallCnt, PERF ? 1 : 0);
    end
  endtask

  task automatic test_mul();
    logic [6:0] exp_plain [4];
    logic [6:0] exp_frz [5];
    exp_plain = '{C_MUL, C_MUL, C_MUL, C_RUN};
    exp_frz   = '{C_MUL, C_FRZM, C_MUL, C_MUL, C_RUN};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      EX_MulStart = (i == 0);
      @(negedge CLK);
      checks++;
      if (ctl() !== exp_plain[i]) begin
        errors++; $display("FAIL mul_cycle%0d: got %b expected %b", i, ctl(), exp_plain[i]);
      end
      tick();
    end
    set_idle();
    for (int i = 0; i < 5; i++) begin
      EX_MulStart = (i == 0);
      DMemReady   = (i != 1);
      @(negedge CLK);
      checks++;
      if (ctl() !== exp_frz[i]) begin
        errors++; $display("FAIL mul_frozen_cycle%0d: got %b expected %b", i, ctl(), exp_frz[i]);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    EX_MulStart = 1'b1;
    tick();
    EX_MulStart = 1'b0;
    ResetN = 1'b0;
    #1;
    checks++;
    if (ctl() !== C_RST) begin
      errors++; $display("FAIL reset_mid_mul: got %b expected %b", ctl(), C_RST);
    end
    tick();
    ResetN = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_RUN) begin
      errors++; $display("FAIL after_reset_mul_abort: got %b expected %b", ctl(), C_RUN);
    end
    tick();
  endtask

  task automatic test_imem_miss();
    do_reset();
    IMemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (ctl() !== C_IMISS) begin
        errors++; $display("FAIL imem_miss%0d: got %b expected %b", i, ctl(), C_IMISS);
      end
      tick();
    end
    IMemReady = 1'b1;
    @(negedge CLK);
    checks++;
    if (StallCnt !== (PERF ? 16'd2 : 16'd0) || FlushCnt !== 16'd0) begin
      errors++;
      $display("FAIL imem_counters: got stall=%0d flush=%0d expected stall=%0d flush=0",
               StallCnt, FlushCnt, PERF ? 2 : 0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Branch held through a freeze is serviced on the first unfrozen cycle
    EX_BranchTaken = 1'b1; DMemReady = 1'b0;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_FRZ) begin
      errors++; $display("FAIL freeze_branch: got %b expected %b", ctl(), C_FRZ);
    end
    tick();
    DMemReady = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl() !== C_BR) begin
      errors++; $display("FAIL branch_after_freeze: got %b expected %b", ctl(), C_BR);
    end
    tick();
    set_idle();
    @(negedge CLK);
    checks++;
    if (FlushCnt !== (PERF ? 16'd1 : 16'd0) || StallCnt !== (PERF ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL freeze_branch_counters: got flush=%0d stall=%0d expected %0d/%0d",
               FlushCnt, StallCnt, PERF ? 1 : 0, PERF ? 1 : 0);
    end
    tick();
  endtask

  initial begin
    ResetN = 1'b0;
    set_idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_reset_mid_mul();
    test_imem_miss();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
